// File: rtl/character_ctrl_pkg.sv
// Shared constants, key codes and state type for the character sprite controller.
// No logic here; the sizing helpers derive counter widths from the sprite geometry.
package char_pkg;

  localparam int SCREEN_W = 640;
  localparam int CH_W     = 23;
  localparam int CH_H     = 30;
  localparam int START_X  = 320;
  localparam int GROUND_Y = 400;
  localparam int X_STEP   = 2;
  localparam int JUMP_V0  = 12;
  localparam int GRAVITY  = 1;
  localparam int ANIM_DIV = 8;
  localparam int N_WALK   = 4;
  localparam int VY_MAX   = 63;

  localparam int FRAME_WORDS = CH_W * CH_H;
  localparam int X_MAX       = SCREEN_W - CH_W;
  localparam int ANIM_W      = $clog2(ANIM_DIV);
  localparam int FIDX_W      = $clog2(N_WALK + 1);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

  typedef enum logic [1:0] {IDLE, WALK, JUMP} move_state_t;

  // frameRAM word address of pixel 0 of animation frame idx
  function automatic logic [11:0] frame_base(input logic [FIDX_W-1:0] idx);
    return 12'(int'(idx) * FRAME_WORDS);
  endfunction

endpackage

// File: rtl/character_ctrl_if.sv
// Keyboard/vsync inputs and sprite geometry outputs of the character controller.
// slave = controller side, master = the environment driving keys and vsync.
interface character_ctrl_if;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [9:0]  chX;
  logic [9:0]  chY;
  logic [9:0]  chW;
  logic [9:0]  chH;
  logic [11:0] sprite_base;
  logic        facing_left;
  logic        tick;

  modport slave (
    input  frame_clk, keycode,
    output chX, chY, chW, chH, sprite_base, facing_left, tick
  );

  modport master (
    output frame_clk, keycode,
    input  chX, chY, chW, chH, sprite_base, facing_left, tick
  );
endinterface

// File: rtl/character_ctrl_frame_tick_sync.sv
// Brings vsync into the Clk domain and emits a one-cycle tick per rising edge.
// tick is high in the cycle after the second sampling edge; no backpressure.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic s1, s2, s3;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= frame_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

endmodule

// File: rtl/character_ctrl.sv
// Per-frame sprite motion (walk, jump, gravity, screen clamp) and animation frame select.
// State advances on the edge after tick, i.e. two Clk edges after vsync is first sampled high.
module character_ctrl
  import char_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  character_ctrl_if.slave  bus
);

  logic tick;

  frame_tick_sync u_sync (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (bus.frame_clk),
    .tick      (tick)
  );

  move_state_t        state, state_n;
  logic [9:0]         ch_x, ch_x_n;
  logic [9:0]         ch_y, ch_y_n;
  logic signed [6:0]  vy, vy_n;
  logic [FIDX_W-1:0]  frame_idx, frame_idx_n;
  logic [ANIM_W-1:0]  anim_cnt, anim_cnt_n;
  logic               facing, facing_n;
  logic               jump_armed, jump_armed_n;
  logic [11:0]        base_q, base_n;

  logic               key_left, key_right, key_jump;
  logic signed [10:0] ny;
  logic signed [7:0]  vy_sum;

  assign key_left  = (bus.keycode == KEY_LEFT);
  assign key_right = (bus.keycode == KEY_RIGHT);
  assign key_jump  = (bus.keycode == KEY_JUMP);

  // Wide signed intermediates so the landing test and the +63 clamp cannot wrap
  assign ny     = $signed({1'b0, ch_y}) + $signed({{4{vy[6]}}, vy});
  assign vy_sum = $signed({vy[6], vy}) + $signed(8'(GRAVITY));

  always_comb begin
    state_n      = state;
    ch_x_n       = ch_x;
    ch_y_n       = ch_y;
    vy_n         = vy;
    frame_idx_n  = frame_idx;
    anim_cnt_n   = anim_cnt;
    facing_n     = facing;
    jump_armed_n = jump_armed;
    base_n       = base_q;

    if (tick) begin
      if (key_left) begin
        ch_x_n   = (ch_x < 10'(X_STEP)) ? 10'd0 : ch_x - 10'(X_STEP);
        facing_n = 1'b1;
      end else if (key_right) begin
        ch_x_n   = (ch_x >= 10'(X_MAX - X_STEP)) ? 10'(X_MAX) : ch_x + 10'(X_STEP);
        facing_n = 1'b0;
      end

      if (!key_jump)
        jump_armed_n = 1'b1;

      case (state)
        IDLE, WALK: begin
          if (key_jump && jump_armed) begin
            state_n      = JUMP;
            vy_n         = 7'(-JUMP_V0);
            jump_armed_n = 1'b0;
          end else if (key_left || key_right) begin
            state_n = WALK;
          end else begin
            state_n = IDLE;
          end
        end
        JUMP: begin
          if (ny >= $signed(11'(GROUND_Y))) begin
            ch_y_n  = 10'(GROUND_Y);
            vy_n    = 7'sd0;
            state_n = (key_left || key_right) ? WALK : IDLE;
          end else begin
            ch_y_n = ny[9:0];
            vy_n   = (vy_sum > $signed(8'(VY_MAX))) ? 7'(VY_MAX) : vy_sum[6:0];
          end
        end
        default: state_n = IDLE;
      endcase

      // Animation follows the state being entered, so the first walk tick already counts
      case (state_n)
        WALK: begin
          if (state == JUMP) begin
            frame_idx_n = '0;
            anim_cnt_n  = '0;
          end else if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
            anim_cnt_n  = '0;
            frame_idx_n = (frame_idx == FIDX_W'(N_WALK - 1)) ? '0 : frame_idx + 1'b1;
          end else begin
            anim_cnt_n  = anim_cnt + 1'b1;
          end
        end
        JUMP: begin
          frame_idx_n = FIDX_W'(N_WALK);
          anim_cnt_n  = '0;
        end
        default: begin
          frame_idx_n = '0;
          anim_cnt_n  = '0;
        end
      endcase

      base_n = frame_base(frame_idx_n);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ch_x       <= 10'(START_X);
      ch_y       <= 10'(GROUND_Y);
      vy         <= 7'sd0;
      frame_idx  <= '0;
      anim_cnt   <= '0;
      facing     <= 1'b0;
      jump_armed <= 1'b1;
      base_q     <= 12'd0;
    end else begin
      state      <= state_n;
      ch_x       <= ch_x_n;
      ch_y       <= ch_y_n;
      vy         <= vy_n;
      frame_idx  <= frame_idx_n;
      anim_cnt   <= anim_cnt_n;
      facing     <= facing_n;
      jump_armed <= jump_armed_n;
      base_q     <= base_n;
    end
  end

  assign bus.chX         = ch_x;
  assign bus.chY         = ch_y;
  assign bus.chW         = 10'(CH_W - 1);
  assign bus.chH         = 10'(CH_H - 1);
  assign bus.sprite_base = base_q;
  assign bus.facing_left = facing;
  assign bus.tick        = tick;

endmodule

// File: tb/tb_character_ctrl.sv
// Randomised and directed bench for character_ctrl against a frame-level motion model.
module tb_character_ctrl;
  import char_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  character_ctrl_if bus ();

  character_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;
  int tick_cnt = 0;

  always @(posedge Clk) if (bus.tick === 1'b1) tick_cnt <= tick_cnt + 1;

  // Model: character physics per frame. mode 0=standing, 1=walking, 2=airborne
  int mx, my, mvy, mframe, msteps, mface, marmed, mmode;

  task automatic model_reset();
    mx = 320; my = 400; mvy = 0; mframe = 0; msteps = 0;
    mface = 0; marmed = 1; mmode = 0;
  endtask

  task automatic model_frame(input logic [7:0] k);
    bit l, r, w;
    int was, nyv;
    l = (k == 8'h04); r = (k == 8'h07); w = (k == 8'h1A);
    if (l) begin mx = (mx - 2 < 0) ? 0 : mx - 2; mface = 1; end
    else if (r) begin mx = (mx + 2 > 617) ? 617 : mx + 2; mface = 0; end
    was = mmode;
    if (mmode == 2) begin
      nyv = my + mvy;
      if (nyv >= 400) begin my = 400; mvy = 0; mmode = (l || r) ? 1 : 0; end
      else begin my = nyv; mvy = (mvy + 1 > 63) ? 63 : mvy + 1; end
    end else if (w && marmed == 1) begin
      mmode = 2; mvy = -12; marmed = 0;
    end else begin
      mmode = (l || r) ? 1 : 0;
    end
    if (!w) marmed = 1;
    if (mmode == 1 && was != 2) begin
      msteps++;
      if (msteps == 8) begin msteps = 0; mframe = (mframe + 1) % 4; end
    end else begin
      msteps = 0;
      mframe = (mmode == 2) ? 4 : 0;
    end
  endtask

  task automatic do_frame(input logic [7:0] k, output int nticks);
    int start;
    start = tick_cnt;
    @(posedge Clk); #1;
    bus.keycode   = k;
    bus.frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 bus.frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    nticks = tick_cnt - start;
    model_frame(k);
  endtask

  task automatic test_reset();
    int t0;
    Reset = 1'b1; bus.frame_clk = 1'b0; bus.keycode = 8'h00;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
    n_total++; if (bus.chX !== 10'd320) $display("FAIL reset_chX got %0d want 320", bus.chX); else n_pass++;
    n_total++; if (bus.chY !== 10'd400) $display("FAIL reset_chY got %0d want 400", bus.chY); else n_pass++;
    n_total++; if (bus.sprite_base !== 12'd0) $display("FAIL reset_base got %0d want 0", bus.sprite_base); else n_pass++;
    n_total++; if (bus.facing_left !== 1'b0) $display("FAIL reset_facing got %0b want 0", bus.facing_left); else n_pass++;
    n_total++; if (bus.tick !== 1'b0) $display("FAIL reset_tick got %0b want 0", bus.tick); else n_pass++;
    n_total++; if (bus.chW !== 10'd22 || bus.chH !== 10'd29)
      $display("FAIL size_consts got %0d/%0d want 22/29", bus.chW, bus.chH); else n_pass++;
    // latency: sampled at edge k, tick after k+1, gone after k+2
    t0 = tick_cnt;
    @(posedge Clk); #1 bus.frame_clk = 1'b1;
    @(posedge Clk); #1;
    n_total++; if (bus.tick !== 1'b0) $display("FAIL tick_early got %0b want 0", bus.tick); else n_pass++;
    @(posedge Clk); #1;
    n_total++; if (bus.tick !== 1'b1) $display("FAIL tick_on got %0b want 1", bus.tick); else n_pass++;
    @(posedge Clk); #1;
    n_total++; if (bus.tick !== 1'b0) $display("FAIL tick_off got %0b want 0", bus.tick); else n_pass++;
    repeat (4) @(posedge Clk);
    #1 bus.frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    model_frame(8'h00);
    n_total++; if (tick_cnt - t0 != 1) $display("FAIL tick_count got %0d want 1", tick_cnt - t0); else n_pass++;
    n_total++; if (bus.chX !== 10'(mx) || bus.chY !== 10'(my))
      $display("FAIL idle_pos got %0d,%0d want %0d,%0d", bus.chX, bus.chY, mx, my); else n_pass++;
  endtask

  task automatic test_walk_right();
    int nt;
    for (int i = 1; i <= 10; i++) begin
      do_frame(8'h07, nt);
      n_total++; if (nt != 1) $display("FAIL walk_ticks f%0d got %0d want 1", i, nt); else n_pass++;
      n_total++; if (bus.chX !== 10'(mx) || bus.sprite_base !== 12'(mframe * 690))
        $display("FAIL walk f%0d got x=%0d base=%0d want x=%0d base=%0d", i, bus.chX, bus.sprite_base, mx, mframe * 690);
      else n_pass++;
      if (i == 8) begin
        n_total++; if (bus.sprite_base !== 12'd690) $display("FAIL walk_anim8 got %0d want 690", bus.sprite_base); else n_pass++;
      end
    end
    n_total++; if (bus.chX !== 10'd340 || bus.facing_left !== 1'b0)
      $display("FAIL walk_end got x=%0d f=%0b want 340/0", bus.chX, bus.facing_left); else n_pass++;
  endtask

  task automatic test_edges();
    int nt;
    int bad = 0;
    for (int i = 0; i < 172; i++) begin
      do_frame(8'h04, nt);
      if (bus.chX !== 10'(mx) || bus.facing_left !== 1'b1 || bus.sprite_base !== 12'(mframe * 690)) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL left_walk got %0d bad frames want 0", bad); else n_pass++;
    n_total++; if (bus.chX !== 10'd0) $display("FAIL left_clamp got %0d want 0", bus.chX); else n_pass++;
    bad = 0;
    for (int i = 0; i < 310; i++) begin
      do_frame(8'h07, nt);
      if (bus.chX !== 10'(mx) || bus.facing_left !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL right_walk got %0d bad frames want 0", bad); else n_pass++;
    n_total++; if (bus.chX !== 10'd617) $display("FAIL right_clamp got %0d want 617", bus.chX); else n_pass++;
    for (int i = 0; i < 40; i++) do_frame(8'h04, nt);
    n_total++; if (bus.chX !== 10'(mx)) $display("FAIL back_left got %0d want %0d", bus.chX, mx); else n_pass++;
  endtask

  task automatic test_jump();
    int nt;
    int bad = 0;
    int land = -1;
    int want_y[3] = '{388, 377, 367};
    do_frame(8'h00, nt);
    for (int i = 0; i < 32; i++) begin
      do_frame(8'h1A, nt);
      if (bus.chY !== 10'(my) || bus.sprite_base !== 12'(mframe * 690)) bad++;
      if (i >= 1 && i <= 3) begin
        n_total++; if (bus.chY !== 10'(want_y[i-1]))
          $display("FAIL jump_rise%0d got %0d want %0d", i, bus.chY, want_y[i-1]); else n_pass++;
      end
      if (i == 12) begin
        n_total++; if (bus.chY !== 10'd322 || bus.sprite_base !== 12'd2760)
          $display("FAIL jump_apex got y=%0d base=%0d want 322/2760", bus.chY, bus.sprite_base); else n_pass++;
      end
      if (land < 0 && i > 0 && bus.chY === 10'd400) land = i;
    end
    n_total++; if (bad != 0) $display("FAIL jump_track got %0d bad frames want 0", bad); else n_pass++;
    n_total++; if (land != 25) $display("FAIL jump_land got frame %0d want 25", land); else n_pass++;
    n_total++; if (bus.chY !== 10'd400 || bus.sprite_base !== 12'd0)
      $display("FAIL held_w_rejump got y=%0d base=%0d want 400/0", bus.chY, bus.sprite_base); else n_pass++;
    do_frame(8'h00, nt);
    do_frame(8'h1A, nt);
    do_frame(8'h1A, nt);
    n_total++; if (bus.chY !== 10'd388) $display("FAIL rearm_jump got %0d want 388", bus.chY); else n_pass++;
    for (int i = 0; i < 30; i++) do_frame(8'h00, nt);
    n_total++; if (bus.chY !== 10'(my)) $display("FAIL rearm_land got %0d want %0d", bus.chY, my); else n_pass++;
  endtask

  task automatic test_jump_walk();
    int nt, x0;
    int bad = 0;
    do_frame(8'h1A, nt);
    x0 = mx;
    for (int i = 1; i <= 30; i++) begin
      do_frame(8'h07, nt);
      if (bus.chX !== 10'(mx) || bus.chY !== 10'(my) || bus.sprite_base !== 12'(mframe * 690)) bad++;
      if (i == 5) begin
        n_total++; if (bus.chX !== 10'(x0 + 10) || bus.sprite_base !== 12'd2760)
          $display("FAIL air_walk got x=%0d base=%0d want %0d/2760", bus.chX, bus.sprite_base, x0 + 10); else n_pass++;
      end
    end
    n_total++; if (bad != 0) $display("FAIL jump_walk got %0d bad frames want 0", bad); else n_pass++;
    n_total++; if (mmode != 1 || bus.chY !== 10'd400 || bus.sprite_base !== 12'(mframe * 690))
      $display("FAIL land_walk got y=%0d base=%0d want 400/%0d", bus.chY, bus.sprite_base, mframe * 690); else n_pass++;
  endtask

  task automatic test_reset_mid_jump();
    int nt, t0;
    do_frame(8'h04, nt);
    do_frame(8'h00, nt);
    for (int i = 0; i < 4; i++) do_frame(8'h1A, nt);
    n_total++; if (bus.chY !== 10'd367 || bus.facing_left !== 1'b1)
      $display("FAIL pre_reset got y=%0d f=%0b want 367/1", bus.chY, bus.facing_left); else n_pass++;
    // vsync pulse is in the synchroniser when Reset hits; its tick must vanish
    t0 = tick_cnt;
    @(posedge Clk); #1 bus.frame_clk = 1'b1;
    @(posedge Clk); #1 bus.frame_clk = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    model_reset();
    n_total++; if (bus.chX !== 10'd320 || bus.chY !== 10'd400 || bus.sprite_base !== 12'd0 || bus.facing_left !== 1'b0)
      $display("FAIL mid_reset got x=%0d y=%0d base=%0d f=%0b want 320/400/0/0",
               bus.chX, bus.chY, bus.sprite_base, bus.facing_left);
    else n_pass++;
    repeat (6) @(posedge Clk);
    #1;
    n_total++; if (tick_cnt != t0) $display("FAIL pending_tick got %0d ticks want 0", tick_cnt - t0); else n_pass++;
    do_frame(8'h1A, nt);
    do_frame(8'h1A, nt);
    n_total++; if (bus.chY !== 10'd388) $display("FAIL post_reset_jump got %0d want 388", bus.chY); else n_pass++;
  endtask

  task automatic test_random();
    int nt;
    int bad = 0;
    int bad_t = 0;
    logic [7:0] k;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    k = 8'h04;
        2, 3:    k = 8'h07;
        4, 5:    k = 8'h1A;
        6:       k = 8'h05;
        7:       k = 8'($urandom);
        default: k = 8'h00;
      endcase
      do_frame(k, nt);
      if (nt != 1) bad_t++;
      if (bus.chX !== 10'(mx) || bus.chY !== 10'(my) || bus.facing_left !== mface[0] ||
          bus.sprite_base !== 12'(mframe * 690)) begin
        if (bad < 5)
          $display("FAIL random f%0d key=%h got x=%0d y=%0d f=%0b base=%0d want x=%0d y=%0d f=%0d base=%0d",
                   i, k, bus.chX, bus.chY, bus.facing_left, bus.sprite_base, mx, my, mface, mframe * 690);
        bad++;
      end
    end
    n_total++; if (bad != 0) $display("FAIL random_total got %0d bad frames want 0", bad); else n_pass++;
    n_total++; if (bad_t != 0) $display("FAIL random_ticks got %0d bad frames want 0", bad_t); else n_pass++;
  endtask

  initial begin
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode = 8'h00;
    model_reset();
    test_reset();
    test_walk_right();
    test_edges();
    test_jump();
    test_jump_walk();
    test_reset_mid_jump();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
